dht11_host: RTL and testbench

DHT11_HOST -- requirements
Module: dht11_host

---
 rtl/dht11_host.sv | 151 +++++++++++++++
 tb/tb_dht11_host.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dht11_host.sv
// DHT11 single-wire read master: start request, sensor response, 40-bit frame decode.
// Define DHT11_HOST_CHECKSUM_EN to add the checksum test and the chk_err output.
module dht11_host #(
  parameter int REQ_LOW_CYC = 18,
  parameter int TIMEOUT_CYC = 200,
  parameter int BIT_THRESH  = 47
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  inout  wire         data_io,
  output logic        busy,
  output logic        done,
  output logic [39:0] data_out,
  output logic        err,
  output logic [2:0]  dbg_state
`ifdef DHT11_HOST_CHECKSUM_EN
  ,
  output logic        chk_err
`endif
);

  // Handshake: start is a one-cycle request accepted only while busy=0; every
  // accepted request ends with exactly one done pulse, err/chk_err valid with it.
  typedef enum logic [2:0] {
    IDLE, REQ_LOW, REQ_REL, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, FINISH
  } state_t;

  localparam logic [8:0] REQ_LIM = 9'(REQ_LOW_CYC);
  localparam logic [8:0] TO_LIM  = 9'(TIMEOUT_CYC);
  localparam logic [8:0] THR_LIM = 9'(BIT_THRESH);

  state_t      state, state_n;
  logic        sync1, sync2, line_d;
  logic        rise, fall;
  logic [7:0]  cnt;
  logic [8:0]  elapsed;
  logic [5:0]  idx;
  logic [39:0] word;
  logic        err_q;
  logic        wait_state, last_bit;
  logic        store_en, store_val, idx_inc, set_err, clr_txn;
  logic        chk_bad;

  assign rise    = sync2 & ~line_d;
  assign fall    = ~sync2 & line_d;
  // Cycles spent in the current state, counting the present one.
  assign elapsed = {1'b0, cnt} + 9'd1;
  assign last_bit   = (idx == 6'd39);
  assign wait_state = (state == REQ_REL) || (state == RESP_LOW) || (state == RESP_HIGH) ||
                      (state == BIT_LOW) || (state == BIT_HIGH);

`ifdef DHT11_HOST_CHECKSUM_EN
  logic [7:0] sum;
  logic       chk_q;
  assign sum     = word[7:0] + word[15:8] + word[23:16] + word[31:24];
  assign chk_bad = (state == FINISH) && (word[39:32] != sum);
  assign chk_err = chk_q | chk_bad;
`else
  assign chk_bad = 1'b0;
`endif

  assign data_io   = (state == REQ_LOW) ? 1'b0 : 1'bz;
  assign busy      = (state != IDLE);
  assign done      = (state == FINISH);
  assign err       = err_q | chk_bad;
  assign dbg_state = state;

  always_comb begin
    state_n   = state;
    store_en  = 1'b0;
    store_val = 1'b0;
    idx_inc   = 1'b0;
    set_err   = 1'b0;
    clr_txn   = 1'b0;
    if (wait_state && elapsed >= TO_LIM) begin
      state_n = FINISH;
      set_err = 1'b1;
    end else begin
      case (state)
        IDLE: if (start) begin
          state_n = REQ_LOW;
          clr_txn = 1'b1;
        end
        REQ_LOW:   if (elapsed >= REQ_LIM) state_n = REQ_REL;
        REQ_REL:   if (fall) state_n = RESP_LOW;
        RESP_LOW:  if (rise) state_n = RESP_HIGH;
        RESP_HIGH: if (fall) state_n = BIT_LOW;
        BIT_LOW:   if (rise) state_n = BIT_HIGH;
        BIT_HIGH: begin
          if (elapsed < THR_LIM) begin
            if (fall) begin
              store_en = 1'b1;
              idx_inc  = 1'b1;
              state_n  = last_bit ? FINISH : BIT_LOW;
            end
          end else if (elapsed == THR_LIM) begin
            // A 1 is committed the moment the high phase reaches the threshold.
            store_en  = 1'b1;
            store_val = 1'b1;
            if (last_bit) state_n = FINISH;
            else if (fall) begin
              idx_inc = 1'b1;
              state_n = BIT_LOW;
            end
          end else if (fall) begin
            idx_inc = 1'b1;
            state_n = BIT_LOW;
          end
        end
        FINISH:  state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      line_d   <= 1'b1;
      cnt      <= '0;
      idx      <= '0;
      word     <= '0;
      data_out <= '0;
      err_q    <= 1'b0;
`ifdef DHT11_HOST_CHECKSUM_EN
      chk_q    <= 1'b0;
`endif
    end else begin
      sync1  <= data_io;
      sync2  <= sync1;
      line_d <= sync2;
      state  <= state_n;
      if (state_n != state) cnt <= '0;
      else if (cnt != 8'hFF) cnt <= cnt + 8'd1;
      if (clr_txn) idx <= '0;
      else if (idx_inc) idx <= idx + 6'd1;
      if (store_en) word[idx] <= store_val;
      if (clr_txn) err_q <= 1'b0;
      else if (set_err || chk_bad) err_q <= 1'b1;
      if (state == FINISH && !err_q && !chk_bad) data_out <= word;
`ifdef DHT11_HOST_CHECKSUM_EN
      if (clr_txn) chk_q <= 1'b0;
      else if (chk_bad) chk_q <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_dht11_host.sv
// Bench for dht11_host: sensor model on a pulled-up bus, scoreboard of expected
// {chk_err, err, data_out} per transaction, direct checks on timing and reset.
module tb_dht11_host;
  localparam int W = 42;

  logic        clk, rst, start;
  wire         data_io;
  logic        busy, done, err;
  logic [39:0] data_out;
  logic [2:0]  dbg_state;
`ifdef DHT11_HOST_CHECKSUM_EN
  logic        chk_err;
`endif

  logic         sens_low;
  int           n_checks, n_bad, done_cnt, txn_cnt;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_e;
  logic         data_pend, prev_done;
  logic [39:0]  pend_data, last_good;

  assign data_io = sens_low ? 1'b0 : 1'bz;
  pullup (data_io);

  dht11_host dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .data_io  (data_io),
    .busy     (busy),
    .done     (done),
    .data_out (data_out),
    .err      (err),
    .dbg_state(dbg_state)
`ifdef DHT11_HOST_CHECKSUM_EN
    ,
    .chk_err  (chk_err)
`endif
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: got no finish, expected finish before 95000 cycles");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] mk_word(input logic [31:0] lo);
    logic [7:0] s;
    s = lo[7:0] + lo[15:8] + lo[23:16] + lo[31:24];
    return {s, lo};
  endfunction

  // Driver tasks
  task automatic hold(input logic lvl, input int n);
    sens_low = ~lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [39:0] w, input int hi1, input int hi0, input int nbits);
    hold(1'b1, 20);
    hold(1'b0, 54);
    hold(1'b1, 80);
    for (int i = 0; i < nbits; i++) begin
      hold(1'b0, 54);
      hold(1'b1, w[i] ? hi1 : hi0);
    end
    if (nbits == 40) hold(1'b0, 54);
    sens_low = 1'b0;
  endtask

  task automatic push_txn(input logic c, input logic e, input logic [39:0] d);
    exp_q.push_back({c, e, d});
    txn_cnt++;
  endtask

  task automatic do_start();
    int low_cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("err_cleared", err, 0);
    low_cyc = 0;
    while (data_io === 1'b0 && low_cyc < 100) begin
      low_cyc++;
      @(negedge clk);
    end
    check("req_low_cycles", low_cyc, 18);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || data_pend) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || data_pend) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
      data_pend = 1'b0;
    end
  endtask

  // Scoreboard: err/chk_err compared with done, data_out the cycle after
  always @(negedge clk) begin
    if (data_pend) begin
      check("data_out", data_out, pend_data);
      data_pend = 1'b0;
    end
    if (!rst && done) begin
      done_cnt++;
      check("done_pulse", prev_done, 0);
      if (exp_q.size() == 0) check("unexpected_done", 1, 0);
      else begin
        exp_e = exp_q.pop_front();
        check("err", err, exp_e[40]);
`ifdef DHT11_HOST_CHECKSUM_EN
        check("chk_err", chk_err, exp_e[41]);
`endif
        pend_data = exp_e[39:0];
        data_pend = 1'b1;
      end
    end
    prev_done = done;
  end

  initial begin
    logic [39:0] w;
    logic [31:0] lo;
    int lat;
    n_checks = 0; n_bad = 0; done_cnt = 0; txn_cnt = 0;
    data_pend = 1'b0; prev_done = 1'b0; last_good = '0;
    rst = 1'b1; start = 1'b0; sens_low = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_data", data_out, 0);
    check("rst_state", dbg_state, 0);
    check("rst_bus", data_io, 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Reference frame with nominal timing
    w = 40'h2A00170013;
    push_txn(1'b0, 1'b0, w);
    last_good = w;
    do_start();
    check("bus_released", data_io, 1);
    send_frame(w, 70, 24, 40);
    wait_drain(500);
    check("done_count_ref", done_cnt, 1);

    // Decision threshold: 47-cycle highs are 1, 46-cycle highs are 0
    lo = $urandom;
    lo[1:0] = 2'b01;
    w = mk_word(lo);
    push_txn(1'b0, 1'b0, w);
    last_good = w;
    do_start();
    send_frame(w, 47, 46, 40);
    wait_drain(500);

    // Random frames
    for (int k = 0; k < 2; k++) begin
      w = mk_word($urandom_range(32'hFFFF_FFFF, 0));
      push_txn(1'b0, 1'b0, w);
      last_good = w;
      do_start();
      send_frame(w, 70, 24, 40);
      wait_drain(500);
    end

    // No response after request: timeout counted from the release cycle
    push_txn(1'b0, 1'b1, last_good);
    do_start();
    lat = 0;
    while (!done && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
    check("timeout_latency", lat, 200);
    wait_drain(10);
    repeat (5) @(negedge clk);
    check("err_held", err, 1);

    // Line stuck high after 12 bits, with a start pulse while busy
    w = mk_word($urandom);
    push_txn(1'b0, 1'b1, last_good);
    do_start();
    send_frame(w, 70, 24, 12);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("busy_ignores_start", busy, 1);
    check("stuck_state", dbg_state, 6);
    wait_drain(400);
    repeat (3) @(negedge clk);
    check("idle_after_stuck", dbg_state, 0);
    check("err_after_stuck", err, 1);

    // Reset in the middle of bit 20
    w = mk_word($urandom);
    do_start();
    send_frame(w, 70, 24, 20);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_bus", data_io, 1);
    check("midrst_err", err, 0);
    check("midrst_data", data_out, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    last_good = '0;

`ifdef DHT11_HOST_CHECKSUM_EN
    // Good frame, then the same frame with a corrupted checksum byte
    w = 40'h2A00170013;
    push_txn(1'b0, 1'b0, w);
    last_good = w;
    do_start();
    send_frame(w, 70, 24, 40);
    wait_drain(500);
    push_txn(1'b1, 1'b1, last_good);
    do_start();
    send_frame(w ^ 40'h01_0000_0000, 70, 24, 40);
    wait_drain(500);
`endif

    repeat (5) @(negedge clk);
    check("done_total", done_cnt, txn_cnt);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
